// File: rtl/matmul_engine_pkg.sv
// Shared types and defaults for the matrix-multiply engine.
// Holds width defaults, operand/result typedefs, FSM states and bench timing.
package matmul_engine_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int BUS_WIDTH_DEF  = 64;
    localparam int MAX_DIM_DEF    = BUS_WIDTH_DEF / DATA_WIDTH_DEF;

    typedef logic signed [DATA_WIDTH_DEF-1:0] elem_t;
    typedef logic signed [BUS_WIDTH_DEF-1:0]  res_t;
    typedef elem_t [MAX_DIM_DEF*MAX_DIM_DEF-1:0] mat_t;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    localparam int CLK_NS  = 10;
    localparam int RST_CYC = 3;

    // Signed overflow of a two's complement add, from the sign bits
    // of both addends and of the sum.
    function automatic logic add_ovf(
        input logic a_msb,
        input logic b_msb,
        input logic s_msb
    );
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/matmul_dot_unit.sv
// Combinational MAX_DIM-lane signed dot product, lanes t >= i_k masked off,
// optional add of a stored C element. o_ovf exists only with MATMUL_OVF_DETECT_EN.
// Ports: i_a_row/i_b_col packed operand vectors (lane t at t*DATA_WIDTH),
//        i_k active lane count, i_acc_en/i_c accumulate input, o_sum result.
module matmul_dot_unit
    import matmul_engine_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int BUS_WIDTH  = BUS_WIDTH_DEF,
    parameter int MAX_DIM    = MAX_DIM_DEF,
    localparam int DIM_W     = $clog2(MAX_DIM) + 1
) (
    input  logic [MAX_DIM*DATA_WIDTH-1:0] i_a_row,
    input  logic [MAX_DIM*DATA_WIDTH-1:0] i_b_col,
    input  logic [DIM_W-1:0]              i_k,
    input  logic                          i_acc_en,
    input  logic [BUS_WIDTH-1:0]          i_c,
`ifdef MATMUL_OVF_DETECT_EN
    output logic                          o_ovf,
`endif
    output logic [BUS_WIDTH-1:0]          o_sum
);

    logic signed [2*DATA_WIDTH-1:0] w_prod;
    logic [BUS_WIDTH-1:0]           w_ext;
    logic [BUS_WIDTH-1:0]           w_acc;
    logic [BUS_WIDTH-1:0]           w_nxt;
`ifdef MATMUL_OVF_DETECT_EN
    logic                           w_ovf;
`endif

    always_comb begin
        w_prod = '0;
        w_ext  = '0;
        w_acc  = '0;
        w_nxt  = '0;
`ifdef MATMUL_OVF_DETECT_EN
        w_ovf  = 1'b0;
`endif
        for (int t = 0; t < MAX_DIM; t++) begin
            w_prod = $signed(i_a_row[t*DATA_WIDTH +: DATA_WIDTH])
                   * $signed(i_b_col[t*DATA_WIDTH +: DATA_WIDTH]);
            // Signed cast sign-extends the full product to bus width.
            w_ext  = BUS_WIDTH'(w_prod);
            if (DIM_W'(t) < i_k) begin
                w_nxt = w_acc + w_ext;
`ifdef MATMUL_OVF_DETECT_EN
                w_ovf = w_ovf | add_ovf(w_acc[BUS_WIDTH-1],
                                        w_ext[BUS_WIDTH-1],
                                        w_nxt[BUS_WIDTH-1]);
`endif
                w_acc = w_nxt;
            end
        end
        if (i_acc_en) begin
            w_nxt = w_acc + i_c;
`ifdef MATMUL_OVF_DETECT_EN
            w_ovf = w_ovf | add_ovf(w_acc[BUS_WIDTH-1],
                                    i_c[BUS_WIDTH-1],
                                    w_nxt[BUS_WIDTH-1]);
`endif
            w_acc = w_nxt;
        end
    end

    assign o_sum = w_acc;
`ifdef MATMUL_OVF_DETECT_EN
    assign o_ovf = w_ovf;
`endif

endmodule

// File: rtl/matmul_engine.sv
// Runtime-dimensioned signed matrix multiply C = A*B (+ stored C), results
// streamed row-major over valid/ready. Optional macro: MATMUL_OVF_DETECT_EN.
// Ports: clk_i/rst_i (sync, active-high), start_i, dim_n_i/dim_k_i/dim_m_i,
//        acc_en_i, a_i/b_i packed operands, res_valid_o/res_ready_i,
//        res_data_o/res_row_o/res_col_o, busy_o, done_o, err_o, ovf_o.
module matmul_engine
    import matmul_engine_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int BUS_WIDTH  = BUS_WIDTH_DEF,
    parameter int MAX_DIM    = BUS_WIDTH / DATA_WIDTH,
    localparam int DIM_W     = $clog2(MAX_DIM) + 1
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  start_i,
    input  logic [DIM_W-1:0]                      dim_n_i,
    input  logic [DIM_W-1:0]                      dim_k_i,
    input  logic [DIM_W-1:0]                      dim_m_i,
    input  logic                                  acc_en_i,
    input  logic [MAX_DIM*MAX_DIM*DATA_WIDTH-1:0] a_i,
    input  logic [MAX_DIM*MAX_DIM*DATA_WIDTH-1:0] b_i,
    output logic                                  res_valid_o,
    input  logic                                  res_ready_i,
    output logic [BUS_WIDTH-1:0]                  res_data_o,
    output logic [DIM_W-1:0]                      res_row_o,
    output logic [DIM_W-1:0]                      res_col_o,
    output logic                                  busy_o,
    output logic                                  done_o,
    output logic                                  err_o,
    output logic                                  ovf_o
);

    localparam int NE = MAX_DIM * MAX_DIM;
    localparam int DW = DATA_WIDTH;
    localparam int BW = BUS_WIDTH;

    state_t r_state;
    state_t w_state_nxt;

    logic [NE*DW-1:0] r_a;
    logic [NE*DW-1:0] r_b;
    logic [NE*BW-1:0] r_c;

    logic [DIM_W-1:0] r_n;
    logic [DIM_W-1:0] r_k;
    logic [DIM_W-1:0] r_m;
    logic [DIM_W-1:0] r_i;
    logic [DIM_W-1:0] r_j;
    logic [DIM_W-1:0] r_row;
    logic [DIM_W-1:0] r_col;
    logic             r_acc;
    logic             r_more;
    logic             r_valid;
    logic             r_err;
    logic [BW-1:0]    r_data;

    logic                 w_dims_ok;
    logic                 w_start_ok;
    logic                 w_load;
    logic                 w_accept;
    logic                 w_last;
    logic [MAX_DIM*DW-1:0] w_a_row;
    logic [MAX_DIM*DW-1:0] w_b_col;
    logic [BW-1:0]        w_c;
    logic [BW-1:0]        w_sum;

    assign w_dims_ok = (dim_n_i != '0) && (dim_n_i <= DIM_W'(MAX_DIM))
                    && (dim_k_i != '0) && (dim_k_i <= DIM_W'(MAX_DIM))
                    && (dim_m_i != '0) && (dim_m_i <= DIM_W'(MAX_DIM));

    assign w_start_ok = (r_state == IDLE) && start_i && w_dims_ok;
    // Output register may take a new element when empty or being drained.
    assign w_load     = (r_state == CALC) && (!r_valid || res_ready_i);
    assign w_accept   = (r_state == CALC) && r_valid && res_ready_i;
    assign w_last     = (r_row == r_n - DIM_W'(1))
                     && (r_col == r_m - DIM_W'(1));

    // Gather row r_i of A, column r_j of B and stored C[r_i][r_j].
    always_comb begin
        w_a_row = '0;
        w_b_col = '0;
        w_c     = '0;
        for (int t = 0; t < MAX_DIM; t++) begin
            w_a_row[t*DW +: DW] = r_a[(int'(r_i)*MAX_DIM + t)*DW +: DW];
            w_b_col[t*DW +: DW] = r_b[(t*MAX_DIM + int'(r_j))*DW +: DW];
        end
        w_c = r_c[(int'(r_i)*MAX_DIM + int'(r_j))*BW +: BW];
    end

`ifdef MATMUL_OVF_DETECT_EN
    logic w_ovf;
    logic r_ovf;
`endif

    matmul_dot_unit #(
        .DATA_WIDTH (DATA_WIDTH),
        .BUS_WIDTH  (BUS_WIDTH),
        .MAX_DIM    (MAX_DIM)
    ) u_dot (
        .i_a_row  (w_a_row),
        .i_b_col  (w_b_col),
        .i_k      (r_k),
        .i_acc_en (r_acc),
        .i_c      (w_c),
`ifdef MATMUL_OVF_DETECT_EN
        .o_ovf    (w_ovf),
`endif
        .o_sum    (w_sum)
    );

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (w_start_ok) w_state_nxt = CALC;
            CALC:    if (w_accept && w_last) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_c     <= '0;
            r_n     <= '0;
            r_k     <= '0;
            r_m     <= '0;
            r_i     <= '0;
            r_j     <= '0;
            r_row   <= '0;
            r_col   <= '0;
            r_acc   <= 1'b0;
            r_more  <= 1'b0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_err   <= (r_state == IDLE) && start_i && !w_dims_ok;
            if (w_start_ok) begin
                r_a    <= a_i;
                r_b    <= b_i;
                r_n    <= dim_n_i;
                r_k    <= dim_k_i;
                r_m    <= dim_m_i;
                r_acc  <= acc_en_i;
                r_i    <= '0;
                r_j    <= '0;
                r_more <= 1'b1;
            end
            if (w_load) begin
                if (r_more) begin
                    r_valid <= 1'b1;
                    r_data  <= w_sum;
                    r_row   <= r_i;
                    r_col   <= r_j;
                    if (r_j == r_m - DIM_W'(1)) begin
                        r_j <= '0;
                        if (r_i == r_n - DIM_W'(1)) r_more <= 1'b0;
                        else r_i <= r_i + DIM_W'(1);
                    end else begin
                        r_j <= r_j + DIM_W'(1);
                    end
                end else begin
                    r_valid <= 1'b0;
                end
            end
            if (w_accept)
                r_c[(int'(r_row)*MAX_DIM + int'(r_col))*BW +: BW] <= r_data;
        end
    end

`ifdef MATMUL_OVF_DETECT_EN
    // Sticky per operation: cleared by an accepted start, held through DONE.
    always_ff @(posedge clk_i) begin
        if (rst_i) r_ovf <= 1'b0;
        else if (w_start_ok) r_ovf <= 1'b0;
        else if (w_load && r_more) r_ovf <= r_ovf | w_ovf;
    end
    assign ovf_o = r_ovf;
`else
    assign ovf_o = 1'b0;
`endif

    assign res_valid_o = r_valid;
    assign res_data_o  = r_data;
    assign res_row_o   = r_row;
    assign res_col_o   = r_col;
    assign busy_o      = (r_state == CALC);
    assign done_o      = (r_state == DONE);
    assign err_o       = r_err;

endmodule

// File: tb/tb_matmul_engine.sv
// Directed self-checking bench for matmul_engine (32/64-bit, MAX_DIM=2).
// Hand-computed products, stalls, errors, reset and accumulate reuse.
module tb_matmul_engine;
    import matmul_engine_pkg::*;

    localparam int DW    = 32;
    localparam int BW    = 64;
    localparam int MD    = 2;
    localparam int DIM_W = $clog2(MD) + 1;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 start = 1'b0;
    logic                 acc = 1'b0;
    logic                 ready = 1'b1;
    logic [DIM_W-1:0]     dn = '0;
    logic [DIM_W-1:0]     dk = '0;
    logic [DIM_W-1:0]     dm = '0;
    logic [MD*MD*DW-1:0]  a = '0;
    logic [MD*MD*DW-1:0]  b = '0;

    logic                 valid;
    logic [BW-1:0]        data;
    logic [DIM_W-1:0]     row;
    logic [DIM_W-1:0]     col;
    logic                 busy;
    logic                 done;
    logic                 err;
    logic                 ovf;

    int passed = 0;
    int total  = 0;

    matmul_engine #(
        .DATA_WIDTH (DW),
        .BUS_WIDTH  (BW),
        .MAX_DIM    (MD)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .dim_n_i     (dn),
        .dim_k_i     (dk),
        .dim_m_i     (dm),
        .acc_en_i    (acc),
        .a_i         (a),
        .b_i         (b),
        .res_valid_o (valid),
        .res_ready_i (ready),
        .res_data_o  (data),
        .res_row_o   (row),
        .res_col_o   (col),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err),
        .ovf_o       (ovf)
    );

    always #(CLK_NS/2) clk = ~clk;

    initial begin
        #(CLK_NS*5000);
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag,
                       input logic [BW-1:0] obs,
                       input logic [BW-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [MD*MD*DW-1:0] pk(input logic [DW-1:0] e0,
                                               input logic [DW-1:0] e1,
                                               input logic [DW-1:0] e2,
                                               input logic [DW-1:0] e3);
        return {e3, e2, e1, e0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input int n, input int k, input int m,
                      input logic ac,
                      input logic [MD*MD*DW-1:0] av,
                      input logic [MD*MD*DW-1:0] bv);
        dn = DIM_W'(n);
        dk = DIM_W'(k);
        dm = DIM_W'(m);
        acc = ac;
        a = av;
        b = bv;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Expects cnt elements on consecutive cycles with ready held high.
    task automatic stream(input string tag, input int cnt, input int m,
                          input logic [BW-1:0] ev [4]);
        for (int e = 0; e < cnt; e++) begin
            tick();
            chk({tag, "_valid"}, BW'(valid), 1);
            chk({tag, "_data"}, data, ev[e]);
            chk({tag, "_row"}, BW'(row), BW'(e / m));
            chk({tag, "_col"}, BW'(col), BW'(e % m));
        end
    endtask

    task automatic fin(input string tag);
        tick();
        chk({tag, "_done"}, BW'(done), 1);
        chk({tag, "_busy"}, BW'(busy), 0);
        chk({tag, "_vld_off"}, BW'(valid), 0);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_valid"}, BW'(valid), 0);
        chk({tag, "_data"}, data, 0);
        chk({tag, "_row"}, BW'(row), 0);
        chk({tag, "_col"}, BW'(col), 0);
        chk({tag, "_busy"}, BW'(busy), 0);
        chk({tag, "_done"}, BW'(done), 0);
        chk({tag, "_err"}, BW'(err), 0);
        chk({tag, "_ovf"}, BW'(ovf), 0);
    endtask

    logic [BW-1:0] ev1 [4] = '{64'd19, 64'd22, 64'd43, 64'd50};
    logic [BW-1:0] ev2 [4] = '{64'd38, 64'd44, 64'd86, 64'd100};
    logic [BW-1:0] ev4 [4] = '{64'hFFFF_FFFF_FFFF_FFF5, 64'd0, 64'd0, 64'd0};
    logic [BW-1:0] ev5 [4] = '{64'h8000_0000_0000_0000, 64'd0, 64'd0, 64'd0};

    initial begin
        repeat (RST_CYC) tick();
        check_idle("rst");
        rst = 1'b0;
        tick();

        go(2, 2, 2, 1'b0, pk(1, 2, 3, 4), pk(5, 6, 7, 8));
        chk("c1_busy", BW'(busy), 1);
        chk("c1_lat", BW'(valid), 0);
        stream("c1", 4, 2, ev1);
        fin("c1");
        tick();
        chk("c1_done_pulse", BW'(done), 0);
        chk("c1_ovf", BW'(ovf), 0);

        go(2, 2, 2, 1'b1, pk(1, 2, 3, 4), pk(5, 6, 7, 8));
        a = pk(32'hDEAD, 32'hBEEF, 7, 9);
        b = '1;
        acc = 1'b0;
        stream("c2", 4, 2, ev2);
        fin("c2");
        tick();

        go(2, 2, 2, 1'b0, pk(1, 2, 3, 4), pk(5, 6, 7, 8));
        tick();
        chk("c3_first", data, 64'd19);
        ready = 1'b0;
        dk = '0;
        start = 1'b1;
        repeat (3) begin
            tick();
            chk("c3_hold_valid", BW'(valid), 1);
            chk("c3_hold_data", data, 64'd19);
            chk("c3_hold_row", BW'(row), 0);
            chk("c3_hold_col", BW'(col), 0);
            chk("c3_busy_err", BW'(err), 0);
        end
        start = 1'b0;
        ready = 1'b1;
        for (int e = 1; e < 4; e++) begin
            tick();
            chk("c3_data", data, ev1[e]);
            chk("c3_row", BW'(row), BW'(e / 2));
            chk("c3_col", BW'(col), BW'(e % 2));
        end
        fin("c3");
        tick();

        go(1, 2, 1, 1'b0, pk(-3, 5, 0, 0), pk(2, 0, -1, 0));
        stream("c4", 1, 1, ev4);
        fin("c4");
        dn = 1; dk = 1; dm = 1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("c4_done_start_busy", BW'(busy), 0);
        tick();
        chk("c4_done_start_busy2", BW'(busy), 0);
        chk("c4_done_start_vld", BW'(valid), 0);

        go(1, 0, 1, 1'b0, pk(1, 1, 1, 1), pk(1, 1, 1, 1));
        chk("c5k_err", BW'(err), 1);
        chk("c5k_busy", BW'(busy), 0);
        chk("c5k_vld", BW'(valid), 0);
        tick();
        chk("c5k_err_pulse", BW'(err), 0);
        go(1, 1, 3, 1'b0, pk(1, 1, 1, 1), pk(1, 1, 1, 1));
        chk("c5m_err", BW'(err), 1);
        chk("c5m_busy", BW'(busy), 0);
        chk("c5m_vld", BW'(valid), 0);
        tick();
        chk("c5m_err_pulse", BW'(err), 0);
        chk("c5m_vld2", BW'(valid), 0);

        go(2, 2, 2, 1'b0, pk(1, 2, 3, 4), pk(5, 6, 7, 8));
        tick();
        tick();
        tick();
        chk("c6_third", data, 64'd43);
        rst = 1'b1;
        tick();
        check_idle("c6_rst");
        rst = 1'b0;
        go(2, 2, 2, 1'b1, pk(1, 2, 3, 4), pk(5, 6, 7, 8));
        stream("c6", 4, 2, ev1);
        fin("c6");
        tick();

`ifdef MATMUL_OVF_DETECT_EN
        go(1, 2, 1, 1'b0,
           pk(32'h8000_0000, 32'h8000_0000, 0, 0),
           pk(32'h8000_0000, 0, 32'h8000_0000, 0));
        stream("c7", 1, 1, ev5);
        chk("c7_ovf", BW'(ovf), 1);
        fin("c7");
        chk("c7_ovf_held", BW'(ovf), 1);
`else
        go(1, 2, 1, 1'b0,
           pk(32'h8000_0000, 32'h8000_0000, 0, 0),
           pk(32'h8000_0000, 0, 32'h8000_0000, 0));
        stream("c7", 1, 1, ev5);
        chk("c7_ovf_off", BW'(ovf), 0);
        fin("c7");
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
